// File: rtl/uart_tx.sv
// Asynchronous-serial transmitter: one start bit, data_width_p data bits sent LSB first, one stop bit.
// Takes one word per valid/ready handshake. All outputs are decoded from registered state.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | line high, ready for a word
// START | start bit (low) for clks_per_bit_p cycles
// DATA  | shift_q[0] on the line, one bit per bit period
// STOP  | stop bit (high); done_o in its final cycle
module uart_tx #(
   parameter int data_width_p   = 8,
   parameter int clks_per_bit_p = 16
) (
   input  logic                    clk,
   input  logic                    reset_n_i,
   input  logic                    valid_i,
   input  logic [data_width_p-1:0] data_i,
   output logic                    ready_o,
   output logic                    tx_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int DIV_W = (clks_per_bit_p > 1) ? $clog2(clks_per_bit_p) : 1;
   localparam int BIT_W = (data_width_p > 1) ? $clog2(data_width_p) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clks_per_bit_p - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(data_width_p - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                  state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [data_width_p-1:0] shift_q, shift_d;
   logic                    div_last;

   assign div_last = (div_q == DIV_LAST);

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            div_d = '0;
            bit_d = '0;
            if (valid_i) begin
               shift_d = data_i;
               state_d = START;
            end
         end
         START: begin
            if (div_last) begin
               div_d   = '0;
               state_d = DATA;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DATA: begin
            if (div_last) begin
               div_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         STOP: begin
            if (div_last) begin
               div_d   = '0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level comes straight from state so reset forces it high without waiting for a clock.
   assign tx_o    = (state_q == START) ? 1'b0 :
                    (state_q == DATA)  ? shift_q[0] : 1'b1;
   assign ready_o = (state_q == IDLE);
   assign busy_o  = (state_q != IDLE);
   assign done_o  = (state_q == STOP) && div_last;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter: accepts one parallel word through a valid/ready handshake and shifts it out on a single line as an asynchronous-serial frame.
- Frame format: start bit (low), data_width_p data bits LSB first, one stop bit (high).
- Sits at the output edge of the design and drives a pad directly.
- Counterpart of the team's serial-in capture logic (dff-based shift/sampling path).

Parameters:
- data_width_p, 8, number of data bits per frame (>= 1).
- clks_per_bit_p, 16, clk cycles per serial bit (>= 1); divider counter width = clog2(clks_per_bit_p), minimum 1 bit.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset_n_i  input  1  asynchronous active-low reset.
- valid_i  input  1  data_i holds a word to send.
- data_i  input  data_width_p  parallel word; sampled only on acceptance.
- ready_o  input-side handshake, output  1  high only in IDLE; transfer occurs on a posedge with valid_i & ready_o.
- tx_o  output  1  serial line, idles high.
- busy_o  output  1  high while a frame is in progress (inverse of ready_o).
- done_o  output  1  one-cycle pulse during the final cycle of the stop bit.

Behaviour:
- Reset (reset_n_i low, asynchronous): state=IDLE, tx_o=1, ready_o=1, busy_o=0, done_o=0, bit/divider counters and shift register cleared. Takes effect immediately, including mid-frame: the line returns high at once and the partial frame is abandoned. Deassertion is synchronous to clk.
- All outputs are registered or decoded from registered state only. No combinational path from valid_i or data_i to any output.
- States:
  - IDLE: tx_o=1, ready_o=1. On valid_i=1, data_i is loaded into the shift register and the state goes to START. With valid_i=0 the state stays IDLE.
  - START: tx_o=0 for exactly clks_per_bit_p cycles, then DATA.
  - DATA: tx_o=shift_reg[0]. Each bit is held for clks_per_bit_p cycles, then the register shifts right. After data_width_p bits, go to STOP.
  - STOP: tx_o=1 for clks_per_bit_p cycles. done_o=1 in the last of these cycles. Then IDLE.
- Latency: acceptance edge E → tx_o low from the cycle after E. Frame length = (data_width_p+2)*clks_per_bit_p cycles. ready_o is low during those cycles and high again in the cycle after done_o.
- Back-to-back: valid_i held high gives one IDLE cycle (tx_o high, acceptance) between the stop bit and the next start bit. Line-high time between frames is clks_per_bit_p+1 cycles.
- valid_i while busy: ignored. There is no queue, and the word is not captured.
- data_i changes after acceptance: no effect on the frame in flight.
- clks_per_bit_p=1: one cycle per bit, no divider stall. Frame is data_width_p+2 cycles.
- Divider counts 0..clks_per_bit_p-1 and wraps. The bit counter counts 0..data_width_p-1. Neither counter ever reaches an out-of-range value.

Test Plan:
- Reset: assert reset_n_i mid-DATA with clks_per_bit_p=4 → tx_o=1, ready_o=1, busy_o=0 in the same cycle, before the next clk edge. After release with valid_i=0, tx_o stays 1.
- Single frame (data_width_p=8, clks_per_bit_p=4), send 0xA5 → tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. ready_o low for 40 cycles. done_o high only in cycle 40.
- Back-to-back 0x00 then 0xFF with valid_i held high → second start bit begins exactly 5 cycles after the first stop bit begins. Second data bits all 1.
- Busy-drop: pulse valid_i with 0x3C during the DATA of a 0x81 frame → 0x81 sent intact, 0x3C never appears, no extra frame.
- clks_per_bit_p=1, data 0x01 → tx_o = 0,1,0,0,0,0,0,0,0,1 on consecutive cycles. ready_o returns high on cycle 11.
- data_i perturbed every cycle after accepting 0x5A → serialized bits still match 0x5A LSB first.
